// File: rtl/fpu_result_fifo.sv
// Result/exception-flag FIFO behind the FP unit: captures on the rising edge of in_done, show-ahead head.
// Optional sticky flag accumulation is compiled in with `define FPU_FFLAGS_ACCUM_EN.
module fpu_result_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_res,
    input  logic          in_ov,
    input  logic          in_un,
    input  logic          in_inv,
    input  logic          in_inexact,
    input  logic          in_done,
    output logic [W-1:0]  out_res,
    output logic [3:0]    out_flags,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          full,
    output logic [AW:0]   count,
    output logic          drop,
    output logic [3:0]    fflags,
    input  logic          fflags_clr
);

    localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] CNT_DEPTH = DEPTH[AW:0];
    localparam logic [AW:0] CNT_ZERO  = {(AW+1){1'b0}};

    logic [W-1:0]  res_mem_r [DEPTH];
    logic [3:0]    flg_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          valid_r;
    logic          full_r;
    logic          drop_r;
    logic          done_q_r;

    logic          ev_s;
    logic          pop_s;
    logic          push_s;
    logic          lost_s;
    logic [3:0]    flags_s;
    logic [3:0]    ev_flags_s;
    logic [AW:0]   count_nxt_s;

    // Capture edge detection, push/pop arbitration and next occupancy.
    always_comb begin
        flags_s     = {in_inv, in_ov, in_un, in_inexact};
        ev_s        = in_done & ~done_q_r;
        pop_s       = valid_r & out_ready;
        push_s      = ev_s & (~full_r | pop_s);
        lost_s      = ev_s & full_r & ~pop_s;
        ev_flags_s  = ev_s ? flags_s : 4'b0000;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy, status flags and the drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
            drop_r   <= 1'b0;
            done_q_r <= 1'b0;
        end else begin
            done_q_r <= in_done;
            drop_r   <= lost_s;
            count_r  <= count_nxt_s;
            valid_r  <= (count_nxt_s != CNT_ZERO);
            full_r   <= (count_nxt_s == CNT_DEPTH);
            // DEPTH is a power of two, so AW-bit pointers wrap on their own.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; contents need no reset because reads are gated by valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            res_mem_r[wr_ptr_r] <= in_res;
            flg_mem_r[wr_ptr_r] <= flags_s;
        end
    end

    assign out_res   = valid_r ? res_mem_r[rd_ptr_r] : {W{1'b0}};
    assign out_flags = valid_r ? flg_mem_r[rd_ptr_r] : 4'b0000;
    assign out_valid = valid_r;
    assign full      = full_r;
    assign count     = count_r;
    assign drop      = drop_r;

`ifdef FPU_FFLAGS_ACCUM_EN
    logic [3:0] fflags_r;

    // Sticky exception flags; a clear still keeps the coincident event's flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags_r <= 4'b0000;
        end else if (fflags_clr) begin
            fflags_r <= ev_flags_s;
        end else begin
            fflags_r <= fflags_r | ev_flags_s;
        end
    end

    assign fflags = fflags_r;
`else
    logic [4:0] unused_acc_s;
    assign unused_acc_s = {fflags_clr, ev_flags_s};
    assign fflags       = 4'b0000;
`endif

endmodule

// File: doc/fpu_result_fifo.md
FPU_RESULT_FIFO -- requirements
Module: fpu_result_fifo

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter W, 32, result word width.
REQ-003 Parameter DEPTH, 4, FIFO entries; power of two, minimum 2.
REQ-004 Parameter AW, 2, log2(DEPTH).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  async reset, active-high.
REQ-007 in_res  input  W  result word from upstream FP unit (sqrt/div/mul).
REQ-008 in_ov, in_un, in_inv, in_inexact  input  1 each  upstream exception flags.
REQ-009 in_done  input  1  upstream done level; capture strobe.
REQ-010 out_res  output  W  head-entry result word.
REQ-011 out_flags  output  4  head-entry flags {inv,ov,un,inexact}.
REQ-012 out_valid  output  1  FIFO non-empty.
REQ-013 out_ready  input  1  consumer accepts head entry.
REQ-014 full  output  1  count == DEPTH.
REQ-015 count  output  AW+1  occupied entries.
REQ-016 drop  output  1  one-cycle pulse: capture lost to full FIFO.
REQ-017 fflags  output  4  sticky accumulated {inv,ov,un,inexact}.
REQ-018 fflags_clr  input  1  synchronous clear of fflags.

Function
REQ-019 Capture event SHALL be the rising edge of in_done: in_done=1 this cycle and registered in_done=0 previous cycle; a held-high in_done yields exactly one event.
REQ-020 On a capture event, in_res and the four flags SHALL be sampled in that same cycle and pushed as one entry.
REQ-021 Pop SHALL occur when out_valid=1 and out_ready=1; out_ready with empty FIFO SHALL have no effect.
REQ-022 out_res/out_flags SHALL be driven from the head storage entry (show-ahead); values are undefined-but-stable when out_valid=0, and SHALL not change while out_valid=1 and no pop.
REQ-023 Push into an empty FIFO SHALL make out_valid=1 on the following cycle (no same-cycle bypass; latency 1).
REQ-024 Push SHALL be accepted when full=0, or when full=1 and a pop occurs in the same cycle.
REQ-025 Push with full=1 and no pop SHALL discard the entry, leave pointers/count unchanged, and assert drop for exactly one cycle.
REQ-026 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-027 Read/write pointers SHALL be AW bits and wrap from DEPTH-1 to 0.
REQ-028 count SHALL never exceed DEPTH nor underflow below 0.
REQ-029 fflags (when compiled in, see REQ-036) SHALL OR in the flags of every capture event, including dropped ones.
REQ-030 fflags_clr SHALL zero fflags next cycle; clr coincident with a capture event SHALL yield exactly that event's flags.

Reset
REQ-031 rst=1 SHALL asynchronously force: count=0, pointers=0, out_valid=0, full=0, drop=0, fflags=0, registered in_done=0.
REQ-032 Storage contents SHALL not require reset; out_res/out_flags reset value SHALL be 0 (read via pointer 0 with storage reset, or gated).
REQ-033 Reset asserted mid-operation SHALL discard all entries; no drop pulse on reset.
REQ-034 After rst deasserts, in_done already high SHALL count as a capture event (registered value is 0).
REQ-035 No output SHALL toggle while rst=1.

Configuration
REQ-036 Macro FPU_FFLAGS_ACCUM_EN: defined -> fflags register and fflags_clr logic per REQ-029/030; undefined -> fflags tied to 4'b0, fflags_clr ignored, no flag-accumulation flops.

Verification
REQ-037 Single push: in_res=32'h3FB504F3, in_inexact=1, in_done rises -> next cycle out_valid=1, out_res=32'h3FB504F3, out_flags=4'b0001, count=1.
REQ-038 in_done held high 5 cycles with out_ready=0 -> count=1 only, drop never asserts.
REQ-039 Five capture events (DEPTH=4), out_ready=0 -> full=1 after 4th, drop=1 one cycle on 5th, count=4, head = 1st word; draining yields words 1-4 in order.
REQ-040 full=1, capture event with out_ready=1 same cycle -> no drop, count stays 4, tail holds new word.
REQ-041 Events with flags inv then ov, then fflags_clr coincident with inexact event -> fflags 4'b1000, 4'b1100, then 4'b0001; with FPU_FFLAGS_ACCUM_EN undefined -> fflags=0 throughout.
REQ-042 rst pulsed with count=3 -> immediately count=0, out_valid=0, fflags=0; first event after reset lands at pointer 0.
